// File: rtl/uart_tx_fifo.sv
`default_nettype none
// uart_tx_fifo: bus-mapped 8N1 UART transmitter with a TX FIFO, programmable
// baud divisor and a level "transmitter drained" interrupt.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int DIV_RESET  = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CS_N,
  input  logic        RD_N,
  input  logic        WR_N,
  input  logic [11:0] Addr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        Intr,
  output logic        uart_txd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_BAUD   = 2'd3;

  localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(2);

  logic [7:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 overflow;
  logic                 ie;
  logic [DIV_WIDTH-1:0] divisor;

  logic [1:0]           state;
  logic [7:0]           shreg;
  logic [2:0]           bit_idx;
  logic [DIV_WIDTH-1:0] clk_cnt;
  logic [DIV_WIDTH-1:0] active_div;
  logic                 txd;
  logic                 intr;

  logic                 wr, rd, push, pop, push_ok, full, empty, busy, bit_end;
  logic [1:0]           sel;
  logic [DIV_WIDTH-1:0] wr_div;
  logic [31:0]          status, rdata;
  logic                 unused_bits;

  assign sel     = Addr[3:2];
  assign wr      = ~CS_N & ~WR_N;
  assign rd      = ~CS_N & ~RD_N;
  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign busy    = (state != IDLE) | ~empty;
  assign push    = wr & (sel == REG_TXDATA);
  assign pop     = (state == IDLE) & ~empty;
  // A push into a full FIFO still lands when the FSM frees a slot that same cycle.
  assign push_ok = push & (~full | pop);
  assign bit_end = (clk_cnt == active_div - DIV_WIDTH'(1));
  assign wr_div  = DataIn[DIV_WIDTH-1:0];
  assign unused_bits = ^{Addr, DataIn};

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= DataIn[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      ie       <= 1'b0;
      divisor  <= DIV_WIDTH'(DIV_RESET);
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && !push_ok)
        overflow <= 1'b1;
      else if (wr && sel == REG_STATUS && DataIn[3])
        overflow <= 1'b0;
      if (wr && sel == REG_CTRL) ie <= DataIn[0];
      if (wr && sel == REG_BAUD) divisor <= (wr_div < DIV_MIN) ? DIV_MIN : wr_div;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      txd        <= 1'b1;
      shreg      <= '0;
      bit_idx    <= '0;
      clk_cnt    <= '0;
      active_div <= DIV_WIDTH'(DIV_RESET);
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg      <= mem[rd_ptr];
            active_div <= divisor;
            clk_cnt    <= '0;
            txd        <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            txd     <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + DIV_WIDTH'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              txd     <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + DIV_WIDTH'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + DIV_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) intr <= 1'b0;
    else       intr <= ie & empty & (state == IDLE);
  end

  always_comb begin
    status          = '0;
    status[0]       = busy;
    status[1]       = full;
    status[2]       = empty;
    status[3]       = overflow;
    status[4 +: CW] = count;
  end

  always_comb begin
    rdata = '0;
    case (sel)
      REG_STATUS: rdata = status;
      REG_CTRL:   rdata = {31'b0, ie};
      REG_BAUD:   rdata = 32'(divisor);
      default:    rdata = '0;
    endcase
  end

  assign DataOut  = rd ? rdata : '0;
  assign Intr     = intr;
  assign uart_txd = txd;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// tb_uart_tx_fifo: scoreboard bench; stimulus queues expected frames and read
// data, independent monitors decode uart_txd and sample bus reads.
module tb_uart_tx_fifo;

  localparam logic [11:0] A_TX   = 12'h0;
  localparam logic [11:0] A_ST   = 12'h4;
  localparam logic [11:0] A_CTRL = 12'h8;
  localparam logic [11:0] A_BAUD = 12'hC;

  typedef struct {
    logic [7:0] data;
    int         div;
    longint     start;
    bit         abort_ok;
  } frame_t;

  typedef struct {
    string       name;
    logic [31:0] val;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        CS_N, RD_N, WR_N;
  logic [11:0] Addr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        Intr;
  logic        uart_txd;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  frame_t exp_q[$];
  rd_t    rd_q[$];

  uart_tx_fifo #(.FIFO_DEPTH(8), .DIV_WIDTH(16), .DIV_RESET(434)) dut (
    .clk     (clk),
    .reset   (rst),
    .CS_N    (CS_N),
    .RD_N    (RD_N),
    .WR_N    (WR_N),
    .Addr    (Addr),
    .DataIn  (DataIn),
    .DataOut (DataOut),
    .Intr    (Intr),
    .uart_txd(uart_txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void push_frame(input logic [7:0] d, input int div, input longint st, input bit ab);
    frame_t f;
    f.data = d; f.div = div; f.start = st; f.abort_ok = ab;
    exp_q.push_back(f);
  endfunction

  // All bus tasks are entered right after a falling edge and drive for one cycle.
  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    CS_N = 1'b0; WR_N = 1'b0; RD_N = 1'b1; Addr = a; DataIn = d;
    @(negedge clk);
    CS_N = 1'b1; WR_N = 1'b1;
  endtask

  task automatic bus_read(input logic [11:0] a, input logic [31:0] exp, input string name);
    rd_t r;
    r.name = name; r.val = exp;
    rd_q.push_back(r);
    CS_N = 1'b0; RD_N = 1'b0; WR_N = 1'b1; Addr = a;
    @(negedge clk);
    CS_N = 1'b1; RD_N = 1'b1;
  endtask

  task automatic bus_rw(input logic [11:0] a, input logic [31:0] d, input logic [31:0] exp, input string name);
    rd_t r;
    r.name = name; r.val = exp;
    rd_q.push_back(r);
    CS_N = 1'b0; RD_N = 1'b0; WR_N = 1'b0; Addr = a; DataIn = d;
    @(negedge clk);
    CS_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    #2;
    if (!CS_N && !RD_N) begin
      rd_t r;
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: DataOut %0h with no expectation", DataOut);
      end else begin
        r = rd_q.pop_front();
        if (DataOut !== r.val) begin
          errors++;
          $display("FAIL %s: DataOut %0h expected %0h", r.name, DataOut, r.val);
        end
      end
    end
  end

  // Frame decoder: checks every sample of the frame against the expected bit.
  initial begin : tx_monitor
    frame_t     e;
    bit         bad, aborted;
    logic [7:0] got;
    logic       expb;
    longint     t0;
    int         n, bp;
    forever begin
      @(negedge clk);
      if (!rst && uart_txd === 1'b0) begin
        checks++;
        t0 = cyc;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame: txd low at cycle %0d, none expected", t0);
          n = 0;
          while (uart_txd === 1'b0 && n < 5000) begin @(negedge clk); n++; end
        end else begin
          e = exp_q.pop_front();
          bad = 1'b0; aborted = 1'b0; got = '0;
          for (int s = 0; s < 10 * e.div; s++) begin
            if (s > 0) @(negedge clk);
            if (rst) begin aborted = 1'b1; break; end
            bp = s / e.div;
            expb = (bp == 0) ? 1'b0 : (bp == 9) ? 1'b1 : e.data[bp-1];
            if (uart_txd !== expb) bad = 1'b1;
            if (bp >= 1 && bp <= 8 && (s % e.div) == e.div / 2) got[bp-1] = uart_txd;
          end
          if (e.start >= 0 && t0 != e.start) bad = 1'b1;
          if (aborted != e.abort_ok) bad = 1'b1;
          if (bad) begin
            errors++;
            $display("FAIL frame: got data %02h start %0d aborted %0d, expected data %02h div %0d start %0d aborted %0d",
                     got, t0, aborted, e.data, e.div, e.start, e.abort_ok);
          end
        end
      end
    end
  end

  initial begin : stimulus
    longint base, s1, wc;
    int     n;
    rst = 1'b1; CS_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1; Addr = '0; DataIn = '0;
    repeat (3) @(negedge clk);
    chk("reset_txd", 32'(uart_txd), 32'd1);
    chk("reset_intr", 32'(Intr), 32'd0);
    chk("reset_dataout", DataOut, 32'd0);
    rst = 1'b0;
    bus_read(A_ST, 32'h04, "status_reset");
    bus_read(A_BAUD, 32'd434, "baud_reset");
    bus_read(A_CTRL, 32'd0, "ctrl_reset");

    // Single frame 0xA5 at 4 clocks per bit
    bus_write(A_BAUD, 32'd4);
    push_frame(8'hA5, 4, cyc + 2, 1'b0);
    bus_write(A_TX, 32'hA5);
    bus_read(A_ST, 32'h11, "status_after_push");
    idle(8);
    bus_read(A_ST, 32'h05, "status_mid_frame");
    idle(40);
    bus_read(A_ST, 32'h04, "status_drained");

    // Burst of 9 bytes fills the FIFO, a 10th overflows
    bus_write(A_BAUD, 32'd2);
    base = cyc + 2;
    for (int k = 0; k < 9; k++) begin
      push_frame(8'(k), 2, base + 21 * k, 1'b0);
      bus_write(A_TX, 32'(k));
    end
    bus_read(A_ST, 32'h83, "status_full");
    bus_write(A_TX, 32'h09);
    bus_read(A_ST, 32'h8B, "status_overflow");
    bus_write(A_ST, 32'h8);
    bus_read(A_ST, 32'h83, "status_ovf_cleared");
    idle(200);
    bus_read(A_ST, 32'h04, "status_burst_drained");

    // Interrupt behaviour, with a simultaneous read+write of CTRL
    bus_write(A_BAUD, 32'd3);
    bus_rw(A_CTRL, 32'd1, 32'd0, "ctrl_rw_prewrite");
    bus_read(A_CTRL, 32'd1, "ctrl_readback");
    chk("intr_idle_empty", 32'(Intr), 32'd1);
    push_frame(8'h96, 3, cyc + 2, 1'b0);
    bus_write(A_TX, 32'h96);
    wc = cyc;
    idle(2);
    chk("intr_frame", 32'(Intr), 32'd0);
    n = 0;
    while (cyc < wc + 31 && n < 100) begin @(negedge clk); n++; end
    chk("intr_last_stop", 32'(Intr), 32'd0);
    idle(1);
    chk("intr_drained", 32'(Intr), 32'd1);
    bus_write(A_CTRL, 32'd0);
    idle(1);
    chk("intr_ie_cleared", 32'(Intr), 32'd0);

    // Divisor clamp and mid-frame divisor change
    bus_write(A_BAUD, 32'd1);
    bus_read(A_BAUD, 32'd2, "baud_min_clamp");
    s1 = cyc + 2;
    push_frame(8'h5A, 2, s1, 1'b0);
    bus_write(A_TX, 32'h5A);
    idle(4);
    bus_write(A_BAUD, 32'd8);
    push_frame(8'hC3, 8, s1 + 21, 1'b0);
    bus_write(A_TX, 32'hC3);
    bus_read(A_BAUD, 32'd8, "baud_readback");
    idle(120);
    bus_read(A_ST, 32'h04, "status_after_baud_change");

    // Reset mid-DATA while a second byte waits in the FIFO
    bus_write(A_BAUD, 32'd4);
    push_frame(8'h3C, 4, cyc + 2, 1'b1);
    bus_write(A_TX, 32'h3C);
    bus_write(A_TX, 32'h77);
    idle(5);
    rst = 1'b1;
    #1;
    chk("reset_txd_async", 32'(uart_txd), 32'd1);
    bus_read(A_ST, 32'h04, "status_in_reset");
    bus_read(A_BAUD, 32'd434, "baud_in_reset");
    idle(2);
    rst = 1'b0;
    idle(100);
    bus_read(A_ST, 32'h04, "status_after_reset");

    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    chk("frames_all_seen", 32'(exp_q.size()), 32'd0);
    chk("reads_all_seen", 32'(rd_q.size()), 32'd0);
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
